branch_resolve_unit: RTL

// - Execute-stage consumer of ALU comparison_flags {lt,gt,eq}.
// - Resolves conditional branches and jumps, and detects direction mispredicts.
// - Issues a registered fetch redirect/flush.
// - Owns the 2-bit saturating branch history table (BHT) that fetch reads for direction prediction.

---
 rtl/branch_resolve_unit_if.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit_if
// Description : Fetch-lookup, execute-resolve and redirect/statistics signals
//               shared between the pipeline and branch_resolve_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_unit_if;
    // Fetch-side prediction lookup
    logic [31:0] if_pc;
    logic        if_pred_taken;
    // Execute-stage instruction and ALU comparison flags {lt,gt,eq}
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jump;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [2:0]  cmp_flags;
    // Redirect / flush and error reporting
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal_branch;
    // Statistics
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    // Pipeline side: drives lookups and EX instructions, consumes redirects
    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_pc, ex_target, ex_pred_taken, cmp_flags,
        input  if_pred_taken, redirect_valid, redirect_pc, illegal_branch,
               stat_branches, stat_mispred
    );

    // Branch unit side
    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_funct3,
               ex_pc, ex_target, ex_pred_taken, cmp_flags,
        output if_pred_taken, redirect_valid, redirect_pc, illegal_branch,
               stat_branches, stat_mispred
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves conditional branches and jumps in EX from the ALU
//               comparison flags, detects direction mispredicts, issues a
//               registered one-cycle fetch redirect, and owns the 2-bit
//               saturating branch history table read by fetch.
//               Optional feature macro: BRU_STATS_EN (resolved/mispredict
//               counters; tied to zero when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int          BHT_ENTRIES = 64,            // power of two, >= 2
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_resolve_unit_if.slave  bru
);

    localparam int         IDX_W        = $clog2(BHT_ENTRIES);
    localparam logic [1:0] C_CTR_INIT   = 2'b01;   // weakly not-taken
    localparam logic [1:0] C_CTR_MAX    = 2'b11;
    localparam logic [1:0] C_CTR_MIN    = 2'b00;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q,    redirect_pc_d;
    logic             illegal_q,        illegal_d;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic             flag_lt;
    logic             flag_eq;
    logic             cond;
    logic             legal;
    logic             acc;
    logic             taken;
    logic             mispredict;
    logic             bht_we;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [1:0]       wr_old;
    logic [1:0]       wr_new;

    assign flag_lt = bru.cmp_flags[2];
    assign flag_eq = bru.cmp_flags[0];

    // The greater-than flag and the PC bits outside the table index are not
    // needed for resolution or lookup.
    logic unused_bits;
    assign unused_bits = ^{bru.cmp_flags[1], bru.if_pc[1:0],
                           bru.if_pc[31:IDX_W+2], bru.ex_pc[1:0]};

    // Branch condition from funct3; unsigned variants share the lt flag
    // because the ALU compare mode was already chosen upstream.
    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (bru.ex_funct3)
            3'b000:         cond = flag_eq;     // BEQ
            3'b001:         cond = ~flag_eq;    // BNE
            3'b100, 3'b110: cond = flag_lt;     // BLT / BLTU
            3'b101, 3'b111: cond = ~flag_lt;    // BGE / BGEU
            default: begin                      // 010 / 011 are not branches
                cond  = 1'b0;
                legal = 1'b0;
            end
        endcase
    end

    // Anything sitting in EX while a redirect is being issued is wrong-path.
    assign acc        = bru.ex_valid & ~redirect_valid_q
                      & (bru.ex_is_branch | bru.ex_is_jump);
    assign taken      = bru.ex_is_jump ? 1'b1 : cond;
    assign mispredict = acc & (taken != bru.ex_pred_taken);

    // Only legal conditional branches train the predictor; jumps never do.
    assign bht_we = acc & ~bru.ex_is_jump & bru.ex_is_branch & legal;
    assign wr_idx = bru.ex_pc[IDX_W+1:2];
    assign wr_old = bht_q[wr_idx];

    // Saturating 2-bit counter step toward the resolved direction
    always_comb begin
        wr_new = wr_old;
        if (taken) begin
            if (wr_old != C_CTR_MAX) wr_new = wr_old + 2'b01;
        end else begin
            if (wr_old != C_CTR_MIN) wr_new = wr_old - 2'b01;
        end
    end

    // Next-state for the registered redirect and illegal-branch pulses
    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        illegal_d        = acc & ~bru.ex_is_jump & bru.ex_is_branch & ~legal;
        if (mispredict) begin
            redirect_pc_d = taken ? bru.ex_target : (bru.ex_pc + 32'd4);
        end
    end

    // Redirect / illegal registers; reset drops any pending redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            illegal_q        <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_q        <= illegal_d;
        end
    end

    // Branch history table: full reinitialisation on reset, one write per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= C_CTR_INIT;
            end
        end else if (bht_we) begin
            bht_q[wr_idx] <= wr_new;
        end
    end

    // Fetch lookup reads the registered table, so a same-cycle update to the
    // same index is not visible until the following cycle.
    assign rd_idx            = bru.if_pc[IDX_W+1:2];
    assign bru.if_pred_taken = bht_q[rd_idx][1];

    assign bru.redirect_valid = redirect_valid_q;
    assign bru.redirect_pc    = redirect_pc_q;
    assign bru.illegal_branch = illegal_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mp_q, stat_mp_d;

    // Counters wrap naturally at 2^32; mispredicts counted as the pulse is issued
    always_comb begin
        stat_br_d = stat_br_q + {31'd0, acc};
        stat_mp_d = stat_mp_q + {31'd0, mispredict};
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign bru.stat_branches = stat_br_q;
    assign bru.stat_mispred  = stat_mp_q;
`else
    assign bru.stat_branches = 32'd0;
    assign bru.stat_mispred  = 32'd0;
`endif

endmodule
`default_nettype wire
